// File: rtl/vga_timing_pkg.sv
// Shared constants, counter-width helper and sync bundle type for the VGA raster generator.
// Default timing is 640x480@60 Hz with a 25 MHz pixel clock.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
   localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

   localparam int H_PORT_W = 11;
   localparam int V_PORT_W = 10;

   function automatic int cnt_width(input int total);
      return (total < 2) ? 1 : $clog2(total);
   endfunction

   localparam int H_CNT_W = cnt_width(DEF_H_TOTAL);
   localparam int V_CNT_W = cnt_width(DEF_V_TOTAL);

   typedef struct packed {
      logic de;
      logic hsync;
      logic vsync;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: the generator drives it (master), pixel/SRAM logic consumes it (slave).
interface vga_timing_if;
   import vga_timing_pkg::*;

   logic [H_PORT_W-1:0] h_cnt;
   logic [V_PORT_W-1:0] v_cnt;
   logic                de;
   logic                hsync;
   logic                vsync;
   logic                EoFrame;

   modport master (output h_cnt, v_cnt, de, hsync, vsync, EoFrame);
   modport slave  (input  h_cnt, v_cnt, de, hsync, vsync, EoFrame);
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth register line with a synchronous active-low reset that loads every stage
// with a given idle value; used to align sync/de with the pixel read latency.
module sync_delay_line #(
   parameter int                WIDTH   = 3,
   parameter int                DEPTH   = 2,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!rst_n) begin
            stage_q[i] <= RST_VAL;
         end else begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator (counters, syncs, display enable, EoFrame).
// Optional macro VGA_SYNC_DELAY_EN delays hsync/vsync/de by SYNC_DELAY cycles.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int SYNC_DELAY = 2
) (
   input  logic         pixel_clk,
   input  logic         rst_n,
   vga_timing_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = cnt_width(H_TOTAL);
   localparam int VW      = cnt_width(V_TOTAL);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_EOF    = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_EOF    = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   if (SYNC_DELAY < 1 || SYNC_DELAY > 8) begin : g_bad_delay
      $error("vga_timing_gen: SYNC_DELAY must be in 1..8");
   end

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   sync_t         sync_q, sync_d;
   logic          eof_q, eof_d;
   sync_t         sync_out;

   // Decode from the next counter values so flags line up with the counters they accompany.
   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
      sync_d.de    = (h_d < H_ACT) && (v_d < V_ACT);
      sync_d.hsync = !((h_d >= HS_START) && (h_d <= HS_END));
      sync_d.vsync = !((v_d >= VS_START) && (v_d <= VS_END));
      eof_d        = (h_d == H_EOF) && (v_d == V_EOF);
   end

   always_ff @(posedge pixel_clk) begin
      if (!rst_n) begin
         h_q    <= '0;
         v_q    <= '0;
         sync_q <= SYNC_IDLE;
         eof_q  <= 1'b0;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         sync_q <= sync_d;
         eof_q  <= eof_d;
      end
   end

`ifdef VGA_SYNC_DELAY_EN
   sync_delay_line #(
      .WIDTH   ($bits(sync_t)),
      .DEPTH   (SYNC_DELAY),
      .RST_VAL (SYNC_IDLE)
   ) u_sync_delay (
      .clk   (pixel_clk),
      .rst_n (rst_n),
      .din   (sync_q),
      .dout  (sync_out)
   );
`else
   assign sync_out = sync_q;
`endif

   assign vga.h_cnt   = H_PORT_W'(h_q);
   assign vga.v_cnt   = V_PORT_W'(v_q);
   assign vga.de      = sync_out.de;
   assign vga.hsync   = sync_out.hsync;
   assign vga.vsync   = sync_out.vsync;
   assign vga.EoFrame = eof_q;

endmodule
